// File: rtl/sram_rr_port_ctrl_pkg.sv
// Shared widths, FSM state and request payload for the two-port SRAM22 access controller.
package sram_rr_port_ctrl_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned WMASK_W = 4;
    localparam int unsigned PERF_W  = 16;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef struct packed {
        logic               we;
        logic [WMASK_W-1:0] wmask;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } req_t;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/sram_rr_port_ctrl_if.sv
// One client port of the SRAM controller: valid/ready request in, strobed read response out.
interface sram_rr_port_ctrl_if;
    import sram_rr_port_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    req_t              req;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant logic; last_q holds the most recently granted port.
module sram_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic ready0_c_o,
    output logic ready1_c_o,
    output logic grant0_c_o,
    output logic grant1_c_o
);

    logic last_q;

    // Ready depends only on the other port's valid and the pointer.
    always_comb begin
        ready0_c_o = en_i & ~(valid1_i & ~last_q);
        ready1_c_o = en_i & ~(valid0_i &  last_q);
        grant0_c_o = valid0_i & ready0_c_o;
        grant1_c_o = valid1_i & ready1_c_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant0_c_o) begin
            last_q <= 1'b0;
        end else if (grant1_c_o) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/sram_rr_port_ctrl.sv
// Round-robin two-client controller for the SRAM22 1024x32 macro with post-reset zero-fill.
// Optional perf counters when SRAM_RR_PORT_CTRL_PERF_EN is defined.
module sram_rr_port_ctrl
    import sram_rr_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_W,
    parameter int unsigned ADDR_WIDTH     = ADDR_W,
    parameter int unsigned WMASK_WIDTH    = WMASK_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sram_rr_port_ctrl_if.slave     p0,
    sram_rr_port_ctrl_if.slave     p1,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   init_done
`ifdef SRAM_RR_PORT_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]      perf_grant0,
    output logic [PERF_W-1:0]      perf_grant1,
    output logic [PERF_W-1:0]      perf_conflict
`endif
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_e                 state_q;
    logic [CNT_W-1:0]       clr_cnt_q;
    logic                   init_done_q;
    logic                   we_q;
    logic [WMASK_WIDTH-1:0] wmask_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  din_q;
    logic                   tag_vld_q;
    logic                   tag_port_q;
    logic                   rsp0_q;
    logic                   rsp1_q;

    logic                   rdy0_c;
    logic                   rdy1_c;
    logic                   grant0_c;
    logic                   grant1_c;
    req_t                   sel_req_c;

    sram_rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (init_done_q),
        .valid0_i   (p0.req_valid),
        .valid1_i   (p1.req_valid),
        .ready0_c_o (rdy0_c),
        .ready1_c_o (rdy1_c),
        .grant0_c_o (grant0_c),
        .grant1_c_o (grant1_c)
    );

    assign sel_req_c = grant1_c ? p1.req : p0.req;

    // Sweep / run FSM; the macro pins, response tag and strobes are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            we_q        <= 1'b0;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            tag_vld_q   <= 1'b0;
            tag_port_q  <= 1'b0;
            rsp0_q      <= 1'b0;
            rsp1_q      <= 1'b0;
        end else begin
            we_q       <= 1'b0;
            wmask_q    <= '0;
            tag_vld_q  <= (grant0_c & ~p0.req.we) | (grant1_c & ~p1.req.we);
            tag_port_q <= grant1_c;
            rsp0_q     <= tag_vld_q & ~tag_port_q;
            rsp1_q     <= tag_vld_q &  tag_port_q;
            case (state_q)
                CLEAR: begin
                    // Top counter bit set means every word has been written.
                    if (clr_cnt_q[ADDR_WIDTH]) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        we_q      <= 1'b1;
                        wmask_q   <= '1;
                        addr_q    <= clr_cnt_q[ADDR_WIDTH-1:0];
                        din_q     <= '0;
                        clr_cnt_q <= clr_cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    init_done_q <= 1'b1;
                    if (grant0_c | grant1_c) begin
                        we_q    <= sel_req_c.we;
                        wmask_q <= WMASK_WIDTH'(sel_req_c.wmask);
                        addr_q  <= ADDR_WIDTH'(sel_req_c.addr);
                        din_q   <= DATA_WIDTH'(sel_req_c.wdata);
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign sram_we      = we_q;
    assign sram_wmask   = wmask_q;
    assign sram_addr    = addr_q;
    assign sram_din     = din_q;
    assign init_done    = init_done_q;

    assign p0.req_ready = rdy0_c;
    assign p1.req_ready = rdy1_c;
    assign p0.rsp_valid = rsp0_q;
    assign p1.rsp_valid = rsp1_q;
    assign p0.rsp_rdata = DATA_W'(sram_dout);
    assign p1.rsp_rdata = DATA_W'(sram_dout);

`ifdef SRAM_RR_PORT_CTRL_PERF_EN
    logic [PERF_W-1:0] pg0_q;
    logic [PERF_W-1:0] pg1_q;
    logic [PERF_W-1:0] pc_q;

    // Grants are impossible before init_done, so only the conflict count needs the RUN gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg0_q <= '0;
            pg1_q <= '0;
            pc_q  <= '0;
        end else begin
            if (grant0_c) begin
                pg0_q <= sat_inc(pg0_q);
            end
            if (grant1_c) begin
                pg1_q <= sat_inc(pg1_q);
            end
            if (init_done_q & p0.req_valid & p1.req_valid) begin
                pc_q <= sat_inc(pc_q);
            end
        end
    end

    assign perf_grant0   = pg0_q;
    assign perf_grant1   = pg1_q;
    assign perf_conflict = pc_q;
`endif

endmodule

// File: doc/sram_rr_port_ctrl.md
Name: sram_rr_port_ctrl

Overview:
Two-requester round-robin access controller for the single-port 1024x32, 8-bit-write-mask SRAM22 macro. It owns the macro's we/wmask/addr/din pins. It arbitrates valid/ready requests from two clients and returns read data with a per-port response strobe. After reset it can run a zero-fill sweep so that silicon contents match the simulation model's all-zeros start.

Parameters:
DATA_WIDTH, 32, SRAM word width; must equal the macro's width.
ADDR_WIDTH, 10, SRAM address width; depth = 1<<ADDR_WIDTH.
WMASK_WIDTH, 4, byte-mask width; DATA_WIDTH/WMASK_WIDTH = 8.
CLEAR_ON_RESET, 1, 1 = run the zero-fill sweep after reset; 0 = go straight to RUN.

Ports:
clk  in  1  single clock; also drives the SRAM macro clk
rst_n  in  1  asynchronous active-low reset
pN_req_valid  in  1  request valid, N in {0,1}
pN_req_ready  out  1  request accepted this cycle when valid & ready
pN_req_we  in  1  1 = write, 0 = read
pN_req_wmask  in  WMASK_WIDTH  byte enables for writes; ignored for reads
pN_req_addr  in  ADDR_WIDTH  word address
pN_req_wdata  in  DATA_WIDTH  write data
pN_rsp_valid  out  1  read data valid for port N; no backpressure
pN_rsp_rdata  out  DATA_WIDTH  read data, meaningful only while pN_rsp_valid is high
sram_we  out  1  to macro we
sram_wmask  out  WMASK_WIDTH  to macro wmask
sram_addr  out  ADDR_WIDTH  to macro addr
sram_din  out  DATA_WIDTH  to macro din
sram_dout  in  DATA_WIDTH  from macro dout
init_done  out  1  high once the controller is in RUN

Behaviour:
- Reset is asynchronous, active-low (rst_n). All of the following apply immediately on assertion:
  - sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0.
  - Both rsp_valid=0 and both req_ready=0.
  - init_done=0.
  - Round-robin pointer last=1, so port 0 wins the first conflict.
- FSM has two states, CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- CLEAR:
  - A counter drives registered writes with sram_we=1, wmask=all-ones, din=0, addr=0..1023, one per cycle.
  - After the write to addr 1023 is registered, the next state is RUN.
  - init_done rises at the 1025th rising edge after rst_n deasserts.
  - Both req_ready stay 0 throughout CLEAR.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- RUN arbitration (combinational):
  - p0_req_ready = RUN & !(p1_req_valid & last==0).
  - p1_req_ready = RUN & !(p0_req_valid & last==1).
  - Ready never depends on the port's own valid.
  - On a grant, last <= granted port. A lone requester is granted every cycle.
- Pipeline and latency:
  - Request accepted at edge k: its fields are registered onto the sram_* pins at k.
  - The macro samples them at k+1.
  - For reads, pN_rsp_valid is high in the cycle between edges k+1 and k+2, and pN_rsp_rdata = sram_dout passthrough.
  - Throughput is one operation per cycle.
- Writes produce no response.
- A write with wmask=0 is a legal no-op that still consumes its slot.
- Read-after-write to the same address on back-to-back cycles returns the new data; the macro's synchronous write ordering guarantees this.
- Idle cycles (no grant): sram_we=0, sram_wmask=0; addr and din hold their values; no rsp_valid. The resulting spurious macro read is discarded.
- A response-tag register (valid bit + port id) tracks the in-flight read. Only one rsp_valid is ever high in a cycle.
- Macro sense-amp pins (sae_muxed/sae_int) are handled outside this block.

Optional Feature:
- Macro: SRAM_RR_PORT_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_grant0, perf_grant1 and perf_conflict, each 16 bits, saturating at 16'hFFFF.
  - The grant counters count accepted requests per port.
  - perf_conflict counts RUN cycles where both ports are valid.
  - All three counters clear on reset and do not count during CLEAR.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package sram_rr_port_ctrl_pkg holds the DATA/ADDR/WMASK width constants, the FSM state enum {CLEAR, RUN}, and a request struct {we, wmask, addr, wdata}.
- One sub-module, sram_rr_arb2: the 2-way round-robin grant logic with its last pointer.

Test Plan:
- Reset with CLEAR_ON_RESET=1: sram_we=1 for 1024 cycles over addr 0..1023 with wmask=4'hF and din=0; init_done rises at edge 1025; a read of addr 5 then returns 32'h0.
- p0 writes addr 3, data 32'hDEADBEEF, wmask 4'b0101; then p0 reads addr 3 back-to-back → p0_rsp_valid exactly 2 cycles after the read's accept cycle, rdata=32'h00AD00EF.
- Both ports continuously valid with reads of addr 1 (p0) and addr 2 (p1) → grants alternate p0,p1,p0,... starting with p0; responses appear on the matching port only; no cycle has both rsp_valid high.
- Only p1 valid for 8 cycles → p1_req_ready=1 every cycle, 8 responses, p0_rsp_valid stays 0.
- rst_n pulsed low at sweep address 500 → outputs reset immediately; sweep restarts at addr 0; init_done rises 1025 edges after release.
- With SRAM_RR_PORT_CTRL_PERF_EN: 10 conflict cycles → perf_conflict=10, perf_grant0=5, perf_grant1=5.
